// File: rtl/ex_stage_pkg.sv
// Shared decode constants, forward-select encoding and state/control enums
// for the MIPS execute stage.
package ex_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;
   localparam logic [5:0] F_ADDU  = 6'h21;
   localparam logic [5:0] F_SUB   = 6'h22;
   localparam logic [5:0] F_SUBU  = 6'h23;
   localparam logic [5:0] F_AND   = 6'h24;
   localparam logic [5:0] F_OR    = 6'h25;
   localparam logic [5:0] F_SLT   = 6'h2A;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MFHI, ALU_MFLO
   } alu_ctrl_e;

   typedef enum logic {MD_IDLE, MD_RUN} md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs, forwarding controls and EX/MEM outputs of the execute stage.
interface ex_stage_if #(parameter int XLEN = 32);
   logic [5:0]      Op;
   logic [5:0]      Funct;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [XLEN-1:0] SignImmE;
   logic [4:0]      RtE;
   logic [4:0]      RdE;
   logic [XLEN-1:0] ResultW;
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic            StallE;
   logic [XLEN-1:0] ALUOutM;
   logic [XLEN-1:0] WriteDataM;
   logic [4:0]      WriteRegM;
   logic            RegWriteM;
   logic            MemWriteM;
   logic            MemtoRegM;

   modport master (
      output Op, Funct, A, B, SignImmE, RtE, RdE, ResultW, ForwardAE, ForwardBE,
      input  StallE, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemWriteM, MemtoRegM
   );

   modport slave (
      input  Op, Funct, A, B, SignImmE, RtE, RdE, ResultW, ForwardAE, ForwardBE,
      output StallE, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemWriteM, MemtoRegM
   );
endinterface

// File: rtl/ex_stage_mul_div_unit.sv
// Iterative multiply/divide on operand magnitudes, one bit per cycle,
// with signs applied when HI/LO are written on the final iteration.
module mul_div_unit
   import ex_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MD_ITERS = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_start,
   input  logic            i_signed,
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_busy,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);
   localparam int            CW   = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(MD_ITERS - 1);

   md_state_e         r_state;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_hi, r_lo;
   logic              r_div, r_neg_q, r_neg_r;
   logic [2*XLEN-1:0] r_acc, r_mcand;
   logic [XLEN-1:0]   r_mplier;

   logic signed [XLEN-1:0] w_a_s, w_b_s;
   logic                   w_a_neg, w_b_neg, w_load;
   logic [XLEN-1:0]        w_a_mag, w_b_mag, w_fin_hi, w_fin_lo;
   logic [XLEN:0]          w_rem_try;
   logic [2*XLEN-1:0]      w_acc_nxt, w_prod_fix;

   assign w_a_s   = i_a;
   assign w_b_s   = i_b;
   assign w_a_neg = i_signed & (w_a_s < 0);
   assign w_b_neg = i_signed & (w_b_s < 0);
   assign w_a_mag = w_a_neg ? -i_a : i_a;
   assign w_b_mag = w_b_neg ? -i_b : i_b;
   assign w_load  = (r_state == MD_IDLE) & i_start;
   assign o_busy  = (r_state == MD_RUN);
   assign o_hi    = r_hi;
   assign o_lo    = r_lo;

   // Divide keeps {remainder, dividend/quotient} in r_acc and the divisor in r_mcand[XLEN-1:0].
   assign w_rem_try = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_mcand[XLEN-1:0]};

   always_comb begin
      w_acc_nxt = r_acc;
      if (r_div) begin
         if (!w_rem_try[XLEN]) w_acc_nxt = {w_rem_try[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
         else                  w_acc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
      end else if (r_mplier[0]) begin
         w_acc_nxt = r_acc + r_mcand;
      end
   end

   assign w_prod_fix = r_neg_q ? -w_acc_nxt : w_acc_nxt;

   always_comb begin
      w_fin_hi = w_prod_fix[2*XLEN-1:XLEN];
      w_fin_lo = w_prod_fix[XLEN-1:0];
      if (r_div) begin
         w_fin_lo = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
         w_fin_hi = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         case (r_state)
            MD_IDLE: if (i_start) begin
               r_state <= MD_RUN;
               r_cnt   <= '0;
            end
            MD_RUN: begin
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) begin
                  r_state <= MD_IDLE;
                  r_hi    <= w_fin_hi;
                  r_lo    <= w_fin_lo;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_load) begin
         r_div    <= i_is_div;
         r_neg_q  <= w_a_neg ^ w_b_neg;
         r_neg_r  <= w_a_neg;
         r_mplier <= w_b_mag;
         if (i_is_div) begin
            r_acc   <= {{XLEN{1'b0}}, w_a_mag};
            r_mcand <= {{XLEN{1'b0}}, w_b_mag};
         end else begin
            r_acc   <= '0;
            r_mcand <= {{XLEN{1'b0}}, w_a_mag};
         end
      end else if (o_busy) begin
         r_acc <= w_acc_nxt;
         if (!r_div) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, multiply/divide with HI/LO
// and the EX/MEM pipeline register.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MD_ITERS = 32
) (
   input  logic     clk,
   input  logic     rst_n,
   ex_stage_if.slave bus
);
   alu_ctrl_e              w_alu_ctrl;
   logic                   w_use_imm, w_zext, w_reg_write, w_mem_write, w_mem_to_reg, w_dst_rd;
   logic                   w_md_op, w_md_signed, w_md_div, w_mf_read, w_md_busy, w_stall;
   logic [XLEN-1:0]        w_src_a, w_fwd_b, w_src_b, w_imm, w_alu_res, w_md_hi, w_md_lo;
   logic signed [XLEN-1:0] w_a_s, w_b_s;

   logic [XLEN-1:0] r_alu_out_p1, r_wdata_p1;
   logic [4:0]      r_wreg_p1;
   logic            r_reg_write_p1, r_mem_write_p1, r_mem_to_reg_p1;

   function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0] sel, input logic [XLEN-1:0] rf,
                                               input logic [XLEN-1:0] wb, input logic [XLEN-1:0] mem);
      case (sel)
         FWD_REG: return rf;
         FWD_WB:  return wb;
         FWD_MEM: return mem;
         default: return rf;
      endcase
   endfunction

   always_comb begin
      w_alu_ctrl   = ALU_ADD;
      w_use_imm    = 1'b0;
      w_zext       = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_dst_rd     = 1'b0;
      w_md_op      = 1'b0;
      w_md_signed  = 1'b0;
      w_md_div     = 1'b0;
      w_mf_read    = 1'b0;
      case (bus.Op)
         OP_RTYPE: begin
            w_dst_rd = 1'b1;
            case (bus.Funct)
               F_ADD, F_ADDU: w_reg_write = 1'b1;
               F_SUB, F_SUBU: begin w_alu_ctrl = ALU_SUB;  w_reg_write = 1'b1; end
               F_AND:         begin w_alu_ctrl = ALU_AND;  w_reg_write = 1'b1; end
               F_OR:          begin w_alu_ctrl = ALU_OR;   w_reg_write = 1'b1; end
               F_SLT:         begin w_alu_ctrl = ALU_SLT;  w_reg_write = 1'b1; end
               F_MFHI:        begin w_alu_ctrl = ALU_MFHI; w_reg_write = 1'b1; w_mf_read = 1'b1; end
               F_MFLO:        begin w_alu_ctrl = ALU_MFLO; w_reg_write = 1'b1; w_mf_read = 1'b1; end
               F_MULT:        begin w_md_op = 1'b1; w_md_signed = 1'b1; end
               F_MULTU:       w_md_op = 1'b1;
               F_DIV:         begin w_md_op = 1'b1; w_md_signed = 1'b1; w_md_div = 1'b1; end
               F_DIVU:        begin w_md_op = 1'b1; w_md_div = 1'b1; end
               default:       ;
            endcase
         end
         OP_ADDI, OP_ADDIU: begin w_use_imm = 1'b1; w_reg_write = 1'b1; end
         OP_SLTI: begin w_alu_ctrl = ALU_SLT; w_use_imm = 1'b1; w_reg_write = 1'b1; end
         OP_ANDI: begin w_alu_ctrl = ALU_AND; w_use_imm = 1'b1; w_zext = 1'b1; w_reg_write = 1'b1; end
         OP_ORI:  begin w_alu_ctrl = ALU_OR;  w_use_imm = 1'b1; w_zext = 1'b1; w_reg_write = 1'b1; end
         OP_LW:   begin w_use_imm = 1'b1; w_reg_write = 1'b1; w_mem_to_reg = 1'b1; end
         OP_SW:   begin w_use_imm = 1'b1; w_mem_write = 1'b1; end
         OP_BEQ:  w_alu_ctrl = ALU_SUB;
         default: ;
      endcase
   end

   // The MEM-stage forward source is this stage's own registered result.
   assign w_src_a = fwd_mux(bus.ForwardAE, bus.A, bus.ResultW, r_alu_out_p1);
   assign w_fwd_b = fwd_mux(bus.ForwardBE, bus.B, bus.ResultW, r_alu_out_p1);
   assign w_imm   = w_zext ? {{(XLEN-16){1'b0}}, bus.SignImmE[15:0]} : bus.SignImmE;
   assign w_src_b = w_use_imm ? w_imm : w_fwd_b;
   assign w_a_s   = w_src_a;
   assign w_b_s   = w_src_b;

   always_comb begin
      w_alu_res = '0;
      case (w_alu_ctrl)
         ALU_ADD:  w_alu_res = w_src_a + w_src_b;
         ALU_SUB:  w_alu_res = w_src_a - w_src_b;
         ALU_AND:  w_alu_res = w_src_a & w_src_b;
         ALU_OR:   w_alu_res = w_src_a | w_src_b;
         ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, (w_a_s < w_b_s)};
         ALU_MFHI: w_alu_res = w_md_hi;
         ALU_MFLO: w_alu_res = w_md_lo;
         default:  w_alu_res = '0;
      endcase
   end

   // Any HI/LO user waits while the unit is busy; everything else keeps flowing.
   assign w_stall    = w_md_busy & (w_md_op | w_mf_read);
   assign bus.StallE = w_stall;

   mul_div_unit #(.XLEN(XLEN), .MD_ITERS(MD_ITERS)) u_mdu (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_start  (w_md_op & ~w_md_busy),
      .i_signed (w_md_signed),
      .i_is_div (w_md_div),
      .i_a      (w_src_a),
      .i_b      (w_fwd_b),
      .o_busy   (w_md_busy),
      .o_hi     (w_md_hi),
      .o_lo     (w_md_lo)
   );

   // EX -> MEM boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alu_out_p1    <= '0;
         r_wdata_p1      <= '0;
         r_wreg_p1       <= '0;
         r_reg_write_p1  <= 1'b0;
         r_mem_write_p1  <= 1'b0;
         r_mem_to_reg_p1 <= 1'b0;
      end else begin
         r_alu_out_p1    <= w_alu_res;
         r_wdata_p1      <= w_fwd_b;
         r_wreg_p1       <= w_dst_rd ? bus.RdE : bus.RtE;
         r_reg_write_p1  <= w_reg_write  & ~w_stall;
         r_mem_write_p1  <= w_mem_write  & ~w_stall;
         r_mem_to_reg_p1 <= w_mem_to_reg & ~w_stall;
      end
   end

   assign bus.ALUOutM    = r_alu_out_p1;
   assign bus.WriteDataM = r_wdata_p1;
   assign bus.WriteRegM  = r_wreg_p1;
   assign bus.RegWriteM  = r_reg_write_p1;
   assign bus.MemWriteM  = r_mem_write_p1;
   assign bus.MemtoRegM  = r_mem_to_reg_p1;

endmodule
